// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared encodings for the memory access controller
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_WORD  = 3'b000,
    OP_UBYTE = 3'b001,
    OP_SBYTE = 3'b010,
    OP_UHALF = 3'b011,
    OP_SHALF = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_SEC = 1'b1;

  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Undefined ops and accesses not aligned to their own size are rejected.
  function automatic logic access_err(input logic [2:0] op, input logic [1:0] addr_lo);
    logic err;
    case (op)
      OP_WORD:            err = (addr_lo != 2'b00);
      OP_UBYTE, OP_SBYTE: err = 1'b0;
      OP_UHALF, OP_SHALF: err = addr_lo[0];
      default:            err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lane_fmt.sv
// rtl/mem_access_ctrl_lane_fmt.sv - store byte-enable/data formatting and load lane extraction
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_fmt,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'b1111;
    wdata_fmt = wdata;
    rdata_ext = rdata;
    case (op)
      OP_UBYTE, OP_SBYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_fmt = {4{wdata[7:0]}};
        rdata_ext = {{24{(op == OP_SBYTE) & byte_lane[7]}}, byte_lane};
      end
      OP_UHALF, OP_SHALF: begin
        be        = 4'b0011 << addr_lo;
        wdata_fmt = {2{wdata[15:0]}};
        rdata_ext = {{16{(op == OP_SHALF) & half_lane[15]}}, half_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - two-requester arbitrated single-outstanding memory access controller
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [5:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic        ptr_q;
  logic        owner_q;
  logic        err_q;
  logic [2:0]  cnt_q;
  logic [31:0] data_q;
  req_t        req_q;

  logic        gnt_any;
  logic        gnt_id;
  req_t        sel;
  logic        sel_err;

  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_rdata;

  // Pointer only matters when both requesters contend.
  always_comb begin
    gnt_any   = |req_valid;
    gnt_id    = (&req_valid) ? ptr_q : (req_valid[1] & ~req_valid[0]);
    req_ready = 2'b00;
    if (state_q == ST_IDLE && gnt_any) begin
      req_ready = gnt_id ? 2'b10 : 2'b01;
    end
    sel.we    = req_we[gnt_id];
    sel.op    = gnt_id ? req_op[5:3] : req_op[2:0];
    sel.addr  = gnt_id ? req_addr[63:32] : req_addr[31:0];
    sel.wdata = gnt_id ? req_wdata[63:32] : req_wdata[31:0];
    sel_err   = access_err(sel.op, sel.addr[1:0]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d = sel_err ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = req_q.we ? ST_RESP : ST_WAIT;
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= REQ_CPU;
      owner_q <= REQ_CPU;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
      data_q  <= 32'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && gnt_any) begin
        req_q   <= sel;
        owner_q <= gnt_id;
        ptr_q   <= ~gnt_id;
        err_q   <= sel_err;
        data_q  <= 32'd0;
      end
      if (state_q == ST_ISSUE && !req_q.we) begin
        cnt_q <= LAT_M1;
      end
      // The final WAIT edge is the one where the counter has run out.
      if (state_q == ST_WAIT) begin
        if (cnt_q == 3'd0) begin
          data_q <= mem_rdata;
        end else begin
          cnt_q <= cnt_q - 3'd1;
        end
      end
    end
  end

  mem_lane_fmt u_lane_fmt (
    .op        (req_q.op),
    .addr_lo   (req_q.addr[1:0]),
    .wdata     (req_q.wdata),
    .rdata     (data_q),
    .be        (fmt_be),
    .wdata_fmt (fmt_wdata),
    .rdata_ext (fmt_rdata)
  );

  always_comb begin
    mem_en     = 1'b0;
    mem_be     = 4'b0000;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    resp_valid = 2'b00;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    if (state_q == ST_ISSUE) begin
      mem_en   = 1'b1;
      mem_addr = {req_q.addr[31:2], 2'b00};
      if (req_q.we) begin
        mem_be    = fmt_be;
        mem_wdata = fmt_wdata;
      end else begin
        mem_be = 4'b1111;
      end
    end
    if (state_q == ST_RESP) begin
      resp_valid = owner_q ? 2'b10 : 2'b01;
      resp_err   = err_q;
      if (!err_q && !req_q.we) begin
        resp_rdata = fmt_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed table, hand sequences and randomized model check
module tb_mem_access_ctrl;

  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        reset, reset3;
  logic [1:0]  req_valid, req_valid3, req_we;
  logic [5:0]  req_op;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_ready, resp_valid, req_ready3, resp_valid3;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        resp_err, mem_en, resp_err3, mem_en3;
  logic [3:0]  mem_be, mem_be3;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(LAT1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .mem_en(mem_en3), .mem_be(mem_be3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  // Memories return data exactly MEM_LAT cycles after the issue cycle, junk otherwise.
  logic [31:0] mem_words [0:63];
  logic        rd_v = 1'b0;
  logic [5:0]  rd_a = 6'd0;
  logic [2:0]  v3 = 3'b000;
  always @(posedge clk) begin
    rd_v <= mem_en;
    rd_a <= mem_addr[7:2];
    v3   <= {v3[1:0], mem_en3};
  end
  assign mem_rdata  = rd_v ? mem_words[rd_a] : 32'h5A5A_5A5A;
  assign mem_rdata3 = v3[2] ? 32'h1357_9BDF : 32'hA5A5_A5A5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] op);
    case (op)
      3'd0:       return 4;
      3'd1, 3'd2: return 1;
      3'd3, 3'd4: return 2;
      default:    return 0;
    endcase
  endfunction

  function automatic logic m_err(input logic [2:0] op, input logic [31:0] addr);
    int sz;
    sz = size_of(op);
    return (sz == 0) || (int'(addr % 4) % sz != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] addr,
                                         input logic [31:0] word);
    int sz;
    int sh;
    logic [31:0] mask, v;
    sz   = size_of(op);
    sh   = 8 * int'(addr % 4);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v    = (word >> sh) & mask;
    if ((op == 3'd2 || op == 3'd4) && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] addr);
    int b;
    b = ((1 << size_of(op)) - 1) << int'(addr % 4);
    return b[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    case (size_of(op))
      1:       return {24'd0, wd[7:0]} * 32'h0101_0101;
      2:       return {16'd0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  task automatic set_req(input int r, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_we[r]          = we;
    req_op[r*3 +: 3]   = op;
    req_addr[r*32 +: 32]  = addr;
    req_wdata[r*32 +: 32] = wd;
  endtask

  int          o_gnt, o_lat, o_en_cnt;
  logic [1:0]  o_rv;
  logic        o_err, o_busy;
  logic [3:0]  o_be;
  logic [31:0] o_rdata, o_addr, o_wdata;

  // Called at a negedge with the DUT idle; valid stays up while busy to probe req_ready.
  task automatic do_txn(input logic [1:0] valid);
    o_gnt = -1; o_lat = -1; o_en_cnt = 0; o_rv = 2'b00; o_err = 1'b0; o_busy = 1'b0;
    o_be = 4'h0; o_rdata = 32'd0; o_addr = 32'd0; o_wdata = 32'd0;
    req_valid = valid;
    #1;
    if (req_ready == 2'b01) o_gnt = 0;
    else if (req_ready == 2'b10) o_gnt = 1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      if (mem_en) begin
        o_en_cnt++; o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata;
      end
      if (req_ready != 2'b00) o_busy = 1'b1;
      if (resp_valid != 2'b00) begin
        o_lat = k; o_rv = resp_valid; o_err = resp_err; o_rdata = resp_rdata;
        break;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic cmp_txn(input int g, input logic e_err, input logic [31:0] e_rdata,
                         input int e_lat, input logic [3:0] e_be, input logic [31:0] e_addr,
                         input logic [31:0] e_wd, input logic chk_wd);
    chk("grant", 32'(o_gnt), 32'(g));
    chk("latency", 32'(o_lat), 32'(e_lat));
    chk("resp_owner", 32'(o_rv), (g == 0) ? 32'd1 : 32'd2);
    chk("resp_err", 32'(o_err), 32'(e_err));
    chk("resp_rdata", o_rdata, e_rdata);
    chk("mem_en_count", 32'(o_en_cnt), (e_be != 4'h0) ? 32'd1 : 32'd0);
    chk("ready_while_busy", 32'(o_busy), 32'd0);
    if (e_be != 4'h0) begin
      chk("mem_be", 32'(o_be), 32'(e_be));
      chk("mem_addr", o_addr, e_addr);
      if (chk_wd) chk("mem_wdata", o_wdata, e_wd);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwdata;
  } vec_t;

  vec_t vt [14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, en, bad, eg;
    logic [31:0] rd;
    logic [1:0] vsel;
    logic        rwe [2];
    logic [2:0]  rop [2];
    logic [31:0] raddr [2];
    logic [31:0] rwd [2];

    vt[0]  = '{1'b0, 3'd0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 3, 4'hF, 32'h0};
    vt[1]  = '{1'b0, 3'd2, 32'h13, 32'h0,        32'h80FF7F01, 1'b0, 32'hFFFFFF80, 3, 4'hF, 32'h0};
    vt[2]  = '{1'b0, 3'd1, 32'h13, 32'h0,        32'h80FF7F01, 1'b0, 32'h00000080, 3, 4'hF, 32'h0};
    vt[3]  = '{1'b1, 3'd4, 32'h22, 32'h1234ABCD, 32'h0,        1'b0, 32'h0,        2, 4'hC, 32'hABCDABCD};
    vt[4]  = '{1'b0, 3'd0, 32'h06, 32'h0,        32'h11111111, 1'b1, 32'h0,        1, 4'h0, 32'h0};
    vt[5]  = '{1'b0, 3'd6, 32'h08, 32'h0,        32'h22222222, 1'b1, 32'h0,        1, 4'h0, 32'h0};
    vt[6]  = '{1'b0, 3'd3, 32'h12, 32'h0,        32'h80FF7F01, 1'b0, 32'h000080FF, 3, 4'hF, 32'h0};
    vt[7]  = '{1'b0, 3'd4, 32'h12, 32'h0,        32'h80FF7F01, 1'b0, 32'hFFFF80FF, 3, 4'hF, 32'h0};
    vt[8]  = '{1'b0, 3'd4, 32'h10, 32'h0,        32'h80FF7F01, 1'b0, 32'h00007F01, 3, 4'hF, 32'h0};
    vt[9]  = '{1'b1, 3'd1, 32'h41, 32'h000000A5, 32'h0,        1'b0, 32'h0,        2, 4'h2, 32'hA5A5A5A5};
    vt[10] = '{1'b1, 3'd0, 32'h44, 32'h11223344, 32'h0,        1'b0, 32'h0,        2, 4'hF, 32'h11223344};
    vt[11] = '{1'b1, 3'd3, 32'h21, 32'h5555AAAA, 32'h0,        1'b1, 32'h0,        1, 4'h0, 32'h0};
    vt[12] = '{1'b0, 3'd2, 32'h11, 32'h0,        32'h80FF7F01, 1'b0, 32'h0000007F, 3, 4'hF, 32'h0};
    vt[13] = '{1'b1, 3'd7, 32'h00, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1, 4'h0, 32'h0};

    for (int i = 0; i < 64; i++) mem_words[i] = $urandom;
    reset = 1'b1; reset3 = 1'b1;
    req_valid = 2'b00; req_valid3 = 2'b00; req_we = 2'b00;
    req_op = 6'd0; req_addr = 64'd0; req_wdata = 64'd0;
    #2;
    reset = 1'b0; reset3 = 1'b0;
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1; reset3 = 1'b1;
    @(negedge clk);

    // Directed table, all on requester 0.
    for (int i = 0; i < 14; i++) begin
      mem_words[vt[i].addr[7:2]] = vt[i].word;
      set_req(0, vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata);
      set_req(1, 1'b0, 3'd0, $urandom, $urandom);
      do_txn(2'b01);
      m_ptr = 1;
      cmp_txn(0, vt[i].exp_err, vt[i].exp_rdata, vt[i].exp_lat, vt[i].exp_be,
              vt[i].addr & 32'hFFFF_FFFC, vt[i].exp_mwdata, vt[i].we);
    end

    // Reset clears the pointer; both held valid must then alternate starting at 0.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, 32'h0, 32'h0);
    set_req(1, 1'b0, 3'd0, 32'h4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      do_txn(2'b11);
      eg = m_ptr;
      m_ptr = 1 - eg;
      cmp_txn(eg, 1'b0, mem_words[eg], LAT1 + 2, 4'hF, 32'(eg * 4), 32'h0, 1'b0);
    end

    // Randomized transactions against the behavioural model.
    for (int n = 0; n < 150; n++) begin
      vsel = 2'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        rwe[r]   = 1'($urandom % 2);
        rop[r]   = ($urandom % 10 < 8) ? 3'($urandom % 5) : 3'($urandom_range(5, 7));
        raddr[r] = $urandom;
        rwd[r]   = $urandom;
        set_req(r, rwe[r], rop[r], raddr[r], rwd[r]);
      end
      eg = (vsel == 2'b11) ? m_ptr : ((vsel == 2'b10) ? 1 : 0);
      m_ptr = 1 - eg;
      do_txn(vsel);
      if (m_err(rop[eg], raddr[eg]))
        cmp_txn(eg, 1'b1, 32'h0, 1, 4'h0, 32'h0, 32'h0, 1'b0);
      else if (rwe[eg])
        cmp_txn(eg, 1'b0, 32'h0, 2, m_be(rop[eg], raddr[eg]), raddr[eg] & 32'hFFFF_FFFC,
                m_wdata(rop[eg], rwd[eg]), 1'b1);
      else
        cmp_txn(eg, 1'b0, m_load(rop[eg], raddr[eg], mem_words[raddr[eg][7:2]]), LAT1 + 2,
                4'hF, raddr[eg] & 32'hFFFF_FFFC, 32'h0, 1'b0);
    end

    // MEM_LAT=3 instance: full load, then a load killed by reset mid-WAIT.
    set_req(0, 1'b0, 3'd0, 32'h20, 32'h0);
    req_valid3 = 2'b01;
    #1;
    chk("d3_grant", 32'(req_ready3), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid3 = 2'b00;
    lat = -1; en = 0; rd = 32'd0;
    for (int k = 1; k <= 16; k++) begin
      if (mem_en3) en++;
      if (resp_valid3 != 2'b00) begin
        lat = k; rd = resp_rdata3;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("d3_latency", 32'(lat), 32'd5);
    chk("d3_rdata", rd, 32'h1357_9BDF);
    chk("d3_mem_en_count", 32'(en), 32'd1);

    set_req(0, 1'b0, 3'd0, 32'h24, 32'h0);
    req_valid3 = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid3 = 2'b00;
    chk("d3_issue", 32'(mem_en3), 32'd1);
    @(negedge clk);
    reset3 = 1'b0;
    #1;
    chk("d3_rst_mem_en", 32'(mem_en3), 32'd0);
    chk("d3_rst_resp_valid", 32'(resp_valid3), 32'd0);
    chk("d3_rst_mem_addr", mem_addr3, 32'd0);
    @(negedge clk);
    reset3 = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_en3 || resp_valid3 != 2'b00) bad = 1;
    end
    chk("d3_dropped_txn", 32'(bad), 32'd0);
    req_valid3 = 2'b11;
    #1;
    chk("d3_ptr_after_reset", 32'(req_ready3), 32'd1);
    req_valid3 = 2'b00;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, range 1..7: cycles from memory issue to mem_rdata valid.
REQ-002 SHALL have one clock and an asynchronous active-low reset, exactly as follows: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have: reset  in  1  asynchronous, active-low.
REQ-004 SHALL have: req_valid  in  2  per-requester request (bit0 = CPU M stage, bit1 = secondary port).
REQ-005 SHALL have: req_ready  out  2  per-requester accept, one-hot or zero.
REQ-006 SHALL have: req_we  in  2  1 = store.
REQ-007 SHALL have: req_op  in  6  3 bits per requester: 000 word, 001 ubyte, 010 sbyte, 011 uhalf, 100 shalf.
REQ-008 SHALL have: req_addr  in  64  32-bit byte address per requester.
REQ-009 SHALL have: req_wdata  in  64  32-bit store data per requester, right-aligned.
REQ-010 SHALL have: resp_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-011 SHALL have: resp_rdata  out  32  extended load data, 0 for stores and errors.
REQ-012 SHALL have: resp_err  out  1  misaligned or illegal op, valid with resp_valid.
REQ-013 SHALL have: mem_en  out  1; mem_be  out  4; mem_addr  out  32 (word-aligned); mem_wdata  out  32; mem_rdata  in  32.

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-015 In IDLE, SHALL assert req_ready combinationally for exactly one valid requester, chosen by the priority pointer; a handshake (valid & ready) latches that requester's we/op/addr/wdata and owner id.
REQ-016 With both requests valid in IDLE, SHALL grant the pointer's requester only; after any grant the pointer SHALL point to the other requester.
REQ-017 Accepted request with op 101-111, word addr[1:0]!=0, or half addr[0]!=0: SHALL go IDLE->RESP, keep mem_en low, and set resp_err=1 and resp_rdata=0.
REQ-018 Otherwise SHALL go IDLE->ISSUE.
REQ-019 In ISSUE, SHALL hold mem_en=1 for exactly one cycle, with mem_addr={addr[31:2],2'b00}.
REQ-020 Loads in ISSUE: mem_be=1111.
REQ-021 Stores in ISSUE: mem_be=0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word; mem_wdata = byte replicated x4, half replicated x2, or word.
REQ-022 Store: SHALL go ISSUE->RESP.
REQ-023 Load: SHALL go ISSUE->WAIT, stay MEM_LAT cycles via down-counter, capture mem_rdata on the last WAIT edge, then enter RESP.
REQ-024 Captured load data SHALL be extended by op and addr[1:0]: byte lane addr[1:0], half lane addr[1]; zero-extend u*, sign-extend s*, word unchanged.
REQ-025 RESP SHALL last one cycle: resp_valid[owner]=1 with data/err, then IDLE. There is no response backpressure.
REQ-026 Latency SHALL be: store = resp 2 cycles after the handshake cycle; load = MEM_LAT+2; error = 1.
REQ-027 req_ready SHALL be 0 outside IDLE; new requests are ignored until IDLE.
REQ-028 mem_en SHALL never be high outside ISSUE.

Reset
REQ-029 reset low SHALL immediately force: state IDLE, pointer to requester 0, counter 0, latched request cleared, mem_en/mem_be/resp_valid/resp_err=0, resp_rdata/mem_addr/mem_wdata=0.
REQ-030 Reset asserted mid-transaction SHALL drop that transaction with no response; the first grant after release goes to requester 0 if it is valid.

Structure
REQ-031 A shared package SHALL hold the op encodings, FSM state encoding, and requester ids.
REQ-032 One sub-module mem_lane_fmt (combinational: store be/wdata formatting and load extraction/extension) SHALL be instantiated once.

Verification
REQ-033 Requester 0, lw at 0x10, MEM_LAT=1, mem_rdata=0xDEADBEEF -> mem_en one cycle with be=1111, addr=0x10; resp_valid[0] 3 cycles after handshake; rdata=0xDEADBEEF; err=0.
REQ-034 lb at 0x13, then lbu at 0x13, mem_rdata=0x80FF7F01 -> lb rdata=0xFFFFFF80; lbu rdata=0x00000080.
REQ-035 sh at 0x22 with wdata=0x1234ABCD -> be=1100, mem_wdata=0xABCDABCD, addr=0x20; resp 2 cycles later, rdata=0.
REQ-036 Both valid in IDLE after reset -> req 0 granted first; with both held, req 1 granted next; grants alternate thereafter.
REQ-037 lw at 0x06 or op 110 -> no mem_en; resp_err=1 one cycle after handshake.
REQ-038 MEM_LAT=3 load with reset pulsed low during WAIT -> mem_en and resp_valid stay 0; FSM back in IDLE; pointer=0.
